// File: rtl/psum_spad_sequencer.sv
// Partial-sum scratchpad sequencer: clear, multi-pass accumulate, then drain.
// Optional abort input/aborted output enabled by defining PSUM_ABORT_EN.
module psum_spad_sequencer #(
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
`ifdef PSUM_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              spad_we,
  output logic [ADDR_W-1:0] spad_waddr,
  output logic              spad_re,
  output logic [ADDR_W-1:0] spad_raddr,
  output logic              acc_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              clear,
  output logic              busy,
  output logic              done
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              r_state, w_state_next;
  logic [LEN_W-1:0]    r_len, w_len_next;
  logic [PASS_W-1:0]   r_passes, w_passes_next;
  logic [ADDR_W-1:0]   r_idx, w_idx_next;
  logic [PASS_W-1:0]   r_pass, w_pass_next;

  logic [LEN_W-1:0]    w_len_clamped;
  logic                w_last_idx;
  logic                w_last_pass;
  logic                w_abort_hit;

  assign w_len_clamped = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  assign w_last_idx    = ({1'b0, r_idx} == (r_len - LEN_W'(1)));
  assign w_last_pass   = (r_pass == (r_passes - PASS_W'(1)));

`ifdef PSUM_ABORT_EN
  assign w_abort_hit = abort && (r_state != IDLE);
`else
  assign w_abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_passes <= '0;
      r_idx    <= '0;
      r_pass   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_len    <= w_len_next;
      r_passes <= w_passes_next;
      r_idx    <= w_idx_next;
      r_pass   <= w_pass_next;
    end
  end

`ifdef PSUM_ABORT_EN
  always_ff @(posedge clk) begin
    if (!rstn) aborted <= 1'b0;
    else       aborted <= w_abort_hit;
  end
`endif

  always_comb begin
    w_state_next  = r_state;
    w_len_next    = r_len;
    w_passes_next = r_passes;
    w_idx_next    = r_idx;
    w_pass_next   = r_pass;
    in_ready      = 1'b0;
    spad_we       = 1'b0;
    spad_waddr    = '0;
    spad_re       = 1'b0;
    spad_raddr    = '0;
    acc_sel       = 1'b0;
    out_valid     = 1'b0;
    clear         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_len_next    = w_len_clamped;
          w_passes_next = cfg_passes;
          if (w_len_clamped == '0 || cfg_passes == '0) w_state_next = DONE;
          else                                         w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        busy         = 1'b1;
        clear        = 1'b1;
        w_idx_next   = '0;
        w_pass_next  = '0;
        w_state_next = ACCUM;
      end
      ACCUM: begin
        busy       = 1'b1;
        in_ready   = 1'b1;
        spad_waddr = r_idx;
        spad_raddr = r_idx;
        if (in_valid) begin
          // First pass overwrites; later passes read-modify-write the same entry.
          spad_we = 1'b1;
          acc_sel = (r_pass != '0);
          spad_re = (r_pass != '0);
          if (w_last_idx) begin
            w_idx_next = '0;
            if (w_last_pass) w_state_next = DRAIN;
            else             w_pass_next  = r_pass + PASS_W'(1);
          end else begin
            w_idx_next = r_idx + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        spad_re    = 1'b1;
        spad_raddr = r_idx;
        if (out_ready) begin
          if (w_last_idx) begin
            w_idx_next   = '0;
            w_state_next = DONE;
          end else begin
            w_idx_next = r_idx + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // Abort wins over every transition and suppresses all strobes this cycle.
    if (w_abort_hit) begin
      w_state_next = IDLE;
      w_idx_next   = r_idx;
      w_pass_next  = r_pass;
      in_ready     = 1'b0;
      spad_we      = 1'b0;
      spad_re      = 1'b0;
      acc_sel      = 1'b0;
      out_valid    = 1'b0;
      clear        = 1'b0;
      done         = 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_spad_sequencer.sv
// Directed table-driven bench for psum_spad_sequencer (DEPTH=12).
module tb_psum_spad_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [4:0] cfg_len;
  logic [3:0] cfg_passes;
  logic       in_valid;
  logic       in_ready;
  logic       spad_we;
  logic [3:0] spad_waddr;
  logic       spad_re;
  logic [3:0] spad_raddr;
  logic       acc_sel;
  logic       out_valid;
  logic       out_ready;
  logic       clear;
  logic       busy;
  logic       done;
`ifdef PSUM_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_spad_sequencer #(.DEPTH(12), .ADDR_W(4), .PASS_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
`ifdef PSUM_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_passes (cfg_passes),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .spad_we    (spad_we),
    .spad_waddr (spad_waddr),
    .spad_re    (spad_re),
    .spad_raddr (spad_raddr),
    .acc_sel    (acc_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clear      (clear),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int len;
    int passes;
    bit vtog;
    int stall_n;
    int writes;
    int acc1;
    int accum;
    int drains;
    int done_cyc;
    int clears;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Runs one job from start to done; start is re-pulsed at cycle 5 with a
  // different config, which must be ignored.
  task automatic run_job(input int vi);
    vec_t v;
    int L, cyc, k, j, stalled, got, done_cyc;
    int n_clear, n_we, n_acc1, n_accum, n_drain, n_busy, n_re, clear_cyc;
    v = vecs[vi];
    L = (v.len > 12) ? 12 : v.len;
    k = 0; j = 0; stalled = 0; got = 0; done_cyc = -1; clear_cyc = -1;
    n_clear = 0; n_we = 0; n_acc1 = 0; n_accum = 0; n_drain = 0; n_busy = 0; n_re = 0;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 5'(v.len); cfg_passes = 4'(v.passes);
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (spad_re) n_re++;
      if (in_ready) n_accum++;
      if (clear) begin n_clear++; clear_cyc = cyc; end
      if (spad_we) begin
        chk($sformatf("v%0d waddr beat%0d", vi, k), int'(spad_waddr), (L == 0) ? -1 : k % L);
        chk($sformatf("v%0d acc_sel beat%0d", vi, k), int'(acc_sel), (k >= L) ? 1 : 0);
        if (acc_sel) n_acc1++;
        n_we++; k++;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("v%0d drain addr %0d", vi, j), int'(spad_raddr), j);
        j++; n_drain++;
      end else if (out_valid) begin
        chk($sformatf("v%0d stall addr", vi), int'(spad_raddr), 2);
        stalled++;
      end
      if (done) begin got = 1; done_cyc = cyc; end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 5 && !got);
      cfg_len = 5'd1; cfg_passes = 4'd1;
      in_valid = v.vtog ? (cyc % 2 == 1) : 1'b1;
      out_ready = !(v.stall_n > 0 && j == 2 && stalled < v.stall_n);
    end
    start = 1'b0;
    if (!got) chk($sformatf("v%0d done timeout", vi), 0, 1);
    chk($sformatf("v%0d done cycle", vi), done_cyc, v.done_cyc);
    chk($sformatf("v%0d writes", vi), n_we, v.writes);
    chk($sformatf("v%0d acc writes", vi), n_acc1, v.acc1);
    chk($sformatf("v%0d accum cycles", vi), n_accum, v.accum);
    chk($sformatf("v%0d drains", vi), n_drain, v.drains);
    chk($sformatf("v%0d clears", vi), n_clear, v.clears);
    if (v.clears > 0) chk($sformatf("v%0d clear cycle", vi), clear_cyc, 1);
    chk($sformatf("v%0d busy cycles", vi), n_busy, v.done_cyc);
    chk($sformatf("v%0d re cycles", vi), n_re, v.acc1 + v.drains + v.stall_n);
    @(negedge clk);
    chk($sformatf("v%0d idle busy", vi), int'(busy), 0);
    chk($sformatf("v%0d idle done", vi), int'(done), 0);
    $display("job v%0d len=%0d passes=%0d done_cyc=%0d writes=%0d drains=%0d",
             vi, v.len, v.passes, done_cyc, n_we, n_drain);
  endtask

  initial begin
    int n_done, n_we;
    //        len pas tog stall wr acc1 accum drn done clr
    vecs[0] = '{4,  3, 0, 0, 12, 8,  12, 4,  18, 1};
    vecs[1] = '{4,  3, 1, 0, 12, 8,  24, 4,  30, 1};
    vecs[2] = '{4,  3, 0, 5, 12, 8,  12, 4,  23, 1};
    vecs[3] = '{0,  3, 0, 0, 0,  0,  0,  0,  1,  0};
    vecs[4] = '{4,  0, 0, 0, 0,  0,  0,  0,  1,  0};
    vecs[5] = '{20, 1, 0, 0, 12, 0,  12, 12, 26, 1};
    vecs[6] = '{1,  1, 0, 0, 1,  0,  1,  1,  4,  1};
    vecs[7] = '{12, 2, 0, 0, 24, 12, 24, 12, 38, 1};

    rstn = 1'b0; start = 1'b0; cfg_len = '0; cfg_passes = '0;
    in_valid = 1'b0; out_ready = 1'b0;
`ifdef PSUM_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset spad_we", int'(spad_we), 0);
    chk("reset spad_re", int'(spad_re), 0);
    chk("reset acc_sel", int'(acc_sel), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset clear", int'(clear), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset waddr", int'(spad_waddr), 0);
    chk("reset raddr", int'(spad_raddr), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_job(i);

    // Reset during ACCUM abandons the job.
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 5'd4; cfg_passes = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset accum in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midreset busy", int'(busy), 0);
    chk("midreset in_ready", int'(in_ready), 0);
    n_done = 0; n_we = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (spad_we) n_we++;
    end
    chk("midreset done pulses", n_done, 0);
    chk("midreset writes", n_we, 0);
    $display("seq midreset done=%0d writes=%0d", n_done, n_we);

`ifdef PSUM_ABORT_EN
    // Abort during DRAIN at idx=1 (cycle 7 for len=4, passes=1).
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 5'd4; cfg_passes = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort raddr", int'(spad_raddr), 1);
    chk("abort we", int'(spad_we), 0);
    chk("abort done", int'(done), 0);
    chk("abort aborted early", int'(aborted), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("aborted pulse", int'(aborted), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort done after", int'(done), 0);
    @(negedge clk);
    chk("aborted clear", int'(aborted), 0);
    $display("seq abort complete");
    run_job(0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
